// File: rtl/blft_wb.sv
// blft_wb: write-back stage after the bilateral filter.
// Buffers filtered pixels in a small FIFO and writes them one at a time to the
// output image memory over a req/ack port. Keeps a written-pixel count, a
// running checksum, a sticky overflow flag and a sticky done flag.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid        filtered pixel present this cycle
//   in_addr/in_data pixel address {row,col} and value
//   in_finish       filter finished (level)
//   mem_req         write request (stage full)
//   mem_addr/wdata  write address/data, stable while mem_req=1
//   mem_ack         write accepted this cycle
//   overflow        sticky: a pixel was dropped
//   pix_cnt         completed writes, saturating at 65536
//   checksum        sum of written data mod 2^24
//   done            sticky completion flag
module blft_wb #(
   parameter int DEPTH = 8,
   parameter int AW    = 16,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [AW-1:0] in_addr,
   input  logic [DW-1:0] in_data,
   input  logic          in_finish,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ack,
   output logic          overflow,
   output logic [16:0]   pix_cnt,
   output logic [23:0]   checksum,
   output logic          done
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      FIN   = 2'd2
   } state_t;

   state_t              state;
   logic [AW+DW-1:0]    fifo_mem [DEPTH];
   // One extra pointer bit distinguishes full from empty.
   logic [PW:0]         wr_ptr;
   logic [PW:0]         rd_ptr;

   logic                fifo_empty;
   logic                fifo_full;
   logic                push_req;
   logic                load;
   logic                push;
   logic                drop;
   logic                write_done;
   logic [AW+DW-1:0]    head;

   // Handshake and FIFO control decode.
   always_comb begin
      fifo_empty = (wr_ptr == rd_ptr);
      fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
      push_req   = in_valid && (state == RUN);
      load       = !fifo_empty && (!mem_req || mem_ack);
      // A full FIFO still accepts a push when the head leaves in the same cycle;
      // the slot being read is the slot being written, and the read sees the old word.
      push       = push_req && (!fifo_full || load);
      drop       = push_req && fifo_full && !load;
      write_done = mem_req && mem_ack;
      head       = fifo_mem[rd_ptr[PW-1:0]];
   end

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr[PW-1:0]] <= {in_addr, in_data};
      end
   end

   // Pointers, write stage, counters, flags and the RUN/DRAIN/FIN sequencer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         overflow  <= 1'b0;
         pix_cnt   <= 17'd0;
         checksum  <= 24'd0;
         done      <= 1'b0;
         state     <= RUN;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (load) begin
            rd_ptr                <= rd_ptr + 1'b1;
            {mem_addr, mem_wdata} <= head;
            mem_req               <= 1'b1;
         end else if (write_done) begin
            mem_req <= 1'b0;
         end
         if (drop) begin
            overflow <= 1'b1;
         end
         if (write_done) begin
            if (pix_cnt != 17'd65536) begin
               pix_cnt <= pix_cnt + 17'd1;
            end
            checksum <= checksum + 24'(mem_wdata);
         end
         case (state)
            RUN: begin
               if (in_finish) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (fifo_empty && !mem_req) begin
                  state <= FIN;
                  done  <= 1'b1;
               end
            end
            FIN: begin
               done <= 1'b1;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_blft_wb.sv
// Directed self-checking bench for blft_wb. A negedge monitor records every
// completed write and checks that address/data hold during a stall; the
// expected write sequence and sums are built by the bench from its own stimulus.
module tb_blft_wb;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [15:0] in_addr;
   logic [7:0]  in_data;
   logic        in_finish;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ack;
   logic        overflow;
   logic [16:0] pix_cnt;
   logic [23:0] checksum;
   logic        done;

   int          n_checks = 0;
   int          n_errors = 0;

   logic [23:0] wr_q[$];
   logic [23:0] exp_q[$];
   logic        prev_req;
   logic        prev_ack;
   logic [23:0] prev_word;

   blft_wb #(.DEPTH(8), .AW(16), .DW(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_addr   (in_addr),
      .in_data   (in_data),
      .in_finish (in_finish),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .overflow  (overflow),
      .pix_cnt   (pix_cnt),
      .checksum  (checksum),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (obs !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Write monitor: mem_ack is driven just after posedge, so at negedge
   // req&ack means the handshake completes on the coming edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (prev_req && !prev_ack && mem_req)
            check("stall_stable", {8'h00, mem_addr, mem_wdata}, {8'h00, prev_word});
         if (mem_req && mem_ack)
            wr_q.push_back({mem_addr, mem_wdata});
      end
      prev_req  <= mem_req && !rst;
      prev_ack  <= mem_ack;
      prev_word <= {mem_addr, mem_wdata};
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_addr   = 16'h0000;
      in_data   = 8'h00;
      in_finish = 1'b0;
      mem_ack   = 1'b0;
      step(2);
      rst = 1'b0;
      wr_q.delete();
      exp_q.delete();
   endtask

   // Present one pixel for one cycle; expect it to be written if keep=1.
   task automatic send(input logic [15:0] a, input logic [7:0] d, input bit keep);
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = d;
      if (keep) exp_q.push_back({a, d});
      step(1);
      in_valid = 1'b0;
   endtask

   task automatic compare_writes(input string tag);
      check({tag, "_count"}, wr_q.size(), exp_q.size());
      for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
         check({tag, "_word"}, {8'h00, wr_q[i]}, {8'h00, exp_q[i]});
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while (!done && k < budget) begin
         step(1);
         k++;
      end
      check("done_timeout", {31'd0, done}, 32'd1);
   endtask

   initial begin
      int sum;
      do_reset();

      // Reset values
      check("rst_req",  {31'd0, mem_req}, 32'd0);
      check("rst_addr", {16'd0, mem_addr}, 32'd0);
      check("rst_data", {24'd0, mem_wdata}, 32'd0);
      check("rst_ovf",  {31'd0, overflow}, 32'd0);
      check("rst_cnt",  {15'd0, pix_cnt}, 32'd0);
      check("rst_sum",  {8'd0, checksum}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);

      // Single pixel, ack tied high: req appears two edges after the sample.
      mem_ack = 1'b1;
      send(16'h0505, 8'h7A, 1'b1);
      check("single_req_t", {31'd0, mem_req}, 32'd0);
      step(1);
      check("single_req",  {31'd0, mem_req}, 32'd1);
      check("single_addr", {16'd0, mem_addr}, 32'h0505);
      check("single_data", {24'd0, mem_wdata}, 32'h7A);
      step(1);
      check("single_req_off", {31'd0, mem_req}, 32'd0);
      check("single_cnt", {15'd0, pix_cnt}, 32'd1);
      check("single_sum", {8'd0, checksum}, 32'h7A);
      step(3);
      check("single_ack_idle", {15'd0, pix_cnt}, 32'd1);
      compare_writes("single");

      // Back-pressure: 5 pixels held for 20 cycles, then released.
      do_reset();
      for (int i = 1; i <= 5; i++)
         send({8'h10, 8'(i)}, 8'(i), 1'b1);
      step(20);
      check("bp_req",  {31'd0, mem_req}, 32'd1);
      check("bp_addr", {16'd0, mem_addr}, 32'h1001);
      check("bp_cnt0", {15'd0, pix_cnt}, 32'd0);
      mem_ack = 1'b1;
      step(8);
      check("bp_cnt", {15'd0, pix_cnt}, 32'd5);
      check("bp_sum", {8'd0, checksum}, 32'd15);
      check("bp_ovf", {31'd0, overflow}, 32'd0);
      compare_writes("bp");

      // Overflow: 10 pixels under stall, 9 fit (8 FIFO + 1 stage).
      do_reset();
      for (int i = 0; i < 10; i++)
         send({8'h20, 8'(i)}, 8'(8'h40 + i), i < 9);
      check("ovf_flag", {31'd0, overflow}, 32'd1);
      mem_ack = 1'b1;
      step(15);
      check("ovf_cnt", {15'd0, pix_cnt}, 32'd9);
      check("ovf_sum", {8'd0, checksum}, 32'd612);
      check("ovf_sticky", {31'd0, overflow}, 32'd1);
      compare_writes("ovf");

      // Finish with everything empty: done two edges after in_finish is sampled.
      do_reset();
      in_finish = 1'b1;
      step(1);
      check("efin_done0", {31'd0, done}, 32'd0);
      step(1);
      check("efin_done1", {31'd0, done}, 32'd1);

      // Finish/drain: 3 pending, later pixels ignored.
      do_reset();
      for (int i = 1; i <= 3; i++)
         send({8'h30, 8'(i)}, 8'(8'h10 * i), 1'b1);
      in_finish = 1'b1;
      step(1);
      for (int i = 0; i < 12; i++)
         send({8'h31, 8'(i)}, 8'hEE, 1'b0);
      check("drain_ovf", {31'd0, overflow}, 32'd0);
      check("drain_done0", {31'd0, done}, 32'd0);
      mem_ack = 1'b1;
      begin
         int k;
         k = 0;
         while (pix_cnt != 17'd3 && k < 20) begin
            step(1);
            k++;
         end
      end
      check("drain_cnt", {15'd0, pix_cnt}, 32'd3);
      check("drain_done_pre", {31'd0, done}, 32'd0);
      step(1);
      check("drain_done", {31'd0, done}, 32'd1);
      send(16'h3F3F, 8'h01, 1'b0);
      step(5);
      check("drain_done_hold", {31'd0, done}, 32'd1);
      check("drain_sum", {8'd0, checksum}, 32'h60);
      compare_writes("drain");

      // Frame: rows/cols 5..20, one pixel per 11 cycles, irregular ack.
      do_reset();
      sum = 0;
      for (int r = 5; r <= 20; r++) begin
         for (int c = 5; c <= 20; c++) begin
            mem_ack = ($urandom_range(0, 3) != 0);
            send({8'(r), 8'(c)}, 8'(r ^ (c * 3)), 1'b1);
            sum += (r ^ (c * 3)) & 8'hFF;
            for (int w = 0; w < 10; w++) begin
               mem_ack = ($urandom_range(0, 3) != 0);
               step(1);
            end
         end
      end
      mem_ack   = 1'b1;
      in_finish = 1'b1;
      wait_done(100);
      check("frame_cnt", {15'd0, pix_cnt}, 32'd256);
      check("frame_sum", {8'd0, checksum}, 32'(sum));
      check("frame_ovf", {31'd0, overflow}, 32'd0);
      compare_writes("frame");

      // Reset mid-write with 4 pixels queued behind the stage.
      do_reset();
      for (int i = 0; i < 5; i++)
         send({8'h50, 8'(i)}, 8'(8'h90 + i), 1'b0);
      step(2);
      check("mrst_req_pre", {31'd0, mem_req}, 32'd1);
      rst = 1'b1;
      #1;
      check("mrst_req",  {31'd0, mem_req}, 32'd0);
      check("mrst_addr", {16'd0, mem_addr}, 32'd0);
      check("mrst_data", {24'd0, mem_wdata}, 32'd0);
      check("mrst_cnt",  {15'd0, pix_cnt}, 32'd0);
      check("mrst_done", {31'd0, done}, 32'd0);
      step(1);
      rst = 1'b0;
      wr_q.delete();
      exp_q.delete();
      mem_ack = 1'b1;
      send(16'h0A0B, 8'h33, 1'b1);
      step(4);
      check("mrst_cnt1", {15'd0, pix_cnt}, 32'd1);
      check("mrst_sum1", {8'd0, checksum}, 32'h33);
      check("mrst_idle", {31'd0, mem_req}, 32'd0);
      compare_writes("mrst");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
